// File: rtl/imm_gen_if.sv
// Stream interface between the ID-stage sequencer and the immediate generator.
// Carries the instruction request channel and the immediate result channel.
interface imm_gen_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
);
   // Request channel
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [2:0]        in_imm_src;
   logic [TAG_W-1:0]  in_tag;

   // Result channel
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [TAG_W-1:0]  out_tag;
   logic              out_err;

   // Producer of instructions / consumer of immediates
   modport master (
      output in_valid, in_instr, in_imm_src, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_err
   );

   // Immediate generator side
   modport slave (
      input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_err
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes all RV32I/RV64I immediate formats,
// extends to XLEN, and passes results through a registered output stage
// backed by a one-entry skid register so in_ready never depends on out_ready.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   imm_gen_if.slave          bus,
   input  logic              clr_err,
   output logic [CNT_W-1:0]  err_count
);

   // Only the two RISC-V base widths are supported
   generate
      if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [2:0] SRC_I     = 3'd0;
   localparam logic [2:0] SRC_S     = 3'd1;
   localparam logic [2:0] SRC_B     = 3'd2;
   localparam logic [2:0] SRC_J     = 3'd3;
   localparam logic [2:0] SRC_U     = 3'd4;
   localparam logic [2:0] SRC_SHAMT = 3'd5;
   localparam logic [2:0] SRC_ZIMM  = 3'd6;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       in_ready_q;
   logic       out_valid_q;
   payload_t   out_q, skid_q;
   payload_t   dec_c;
   logic       accept_c, drain_c;
   logic       load_out_in_c, load_out_skid_c, load_skid_c;
   logic       unused_instr_c;

   assign accept_c = bus.in_valid && in_ready_q;
   assign drain_c  = out_valid_q && bus.out_ready;

   // Opcode/rd-only bits never feed any immediate
   assign unused_instr_c = ^bus.in_instr[6:0];

   // Format decode and extension of the incoming instruction
   always_comb begin
      dec_c     = '0;
      dec_c.tag = bus.in_tag;
      case (bus.in_imm_src)
         SRC_I:     dec_c.imm = XLEN'($signed(bus.in_instr[31:20]));
         SRC_S:     dec_c.imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
         SRC_B:     dec_c.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                               bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
         SRC_J:     dec_c.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                               bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
         SRC_U:     dec_c.imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
         SRC_SHAMT: dec_c.imm = (XLEN == 32) ? XLEN'(bus.in_instr[24:20])
                                             : XLEN'(bus.in_instr[25:20]);
         SRC_ZIMM:  dec_c.imm = XLEN'(bus.in_instr[19:15]);
         default:   dec_c.err = 1'b1;
      endcase
   end

   // Occupancy state and registered handshake flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != TWO);
         out_valid_q <= (state_d != EMPTY);
      end
   end

   // Next-state and datapath load selection
   always_comb begin
      state_d         = state_q;
      load_out_in_c   = 1'b0;
      load_out_skid_c = 1'b0;
      load_skid_c     = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept_c) begin
               load_out_in_c = 1'b1;
               state_d       = ONE;
            end
         end
         ONE: begin
            if (accept_c && drain_c) begin
               load_out_in_c = 1'b1;
            end else if (accept_c) begin
               load_skid_c = 1'b1;
               state_d     = TWO;
            end else if (drain_c) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (drain_c) begin
               load_out_skid_c = 1'b1;
               state_d         = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output and skid payload registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_in_c) begin
            out_q <= dec_c;
         end else if (load_out_skid_c) begin
            out_q <= skid_q;
         end
         if (load_skid_c) begin
            skid_q <= dec_c;
         end
      end
   end

   // Saturating count of accepted illegal selects; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= '0;
      end else if (accept_c && dec_c.err && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm   = out_q.imm;
   assign bus.out_tag   = out_q.tag;
   assign bus.out_err   = out_q.err;

endmodule
